// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port SRAM macro between the AHB SRAM slave (A) and a B requester
module sram_port_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          A_CS,
  input  logic [3:0]    A_WEN,
  input  logic [AW-3:0] A_ADDR,
  input  logic [31:0]   A_WDATA,
  output logic [31:0]   A_RDATA,
  input  logic          B_VALID,
  output logic          B_READY,
  input  logic          B_WRITE,
  input  logic [3:0]    B_WEN,
  input  logic [AW-3:0] B_ADDR,
  input  logic [31:0]   B_WDATA,
  output logic          B_RVALID,
  output logic [31:0]   B_RDATA,
  output logic          M_CS,
  output logic [3:0]    M_WEN,
  output logic [AW-3:0] M_ADDR,
  output logic [31:0]   M_WDATA,
  input  logic [31:0]   M_RDATA,
  output logic          STARVE,
  output logic [7:0]    WAIT_CNT
);
  localparam int         WW         = AW - 2;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic          pend_q, pend_d;
  logic          req_write_q, req_write_d;
  logic [3:0]    req_wen_q, req_wen_d;
  logic [WW-1:0] req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [31:0]   rd_hold_q, rd_hold_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          issue_b;
  logic          b_ready;
  logic          accept;

  // Macro mux: A owns any cycle it selects, the held B request fills the idle ones
  always_comb begin
    issue_b = pend_q & ~A_CS;
    b_ready = ~pend_q | issue_b;
    accept  = B_VALID & b_ready;
    M_CS    = 1'b0;
    M_WEN   = 4'b0000;
    M_ADDR  = A_ADDR;
    M_WDATA = A_WDATA;
    if (A_CS) begin
      M_CS  = 1'b1;
      M_WEN = A_WEN;
    end else if (issue_b) begin
      M_CS    = 1'b1;
      M_WEN   = req_write_q ? req_wen_q : 4'b0000;
      M_ADDR  = req_addr_q;
      M_WDATA = req_wdata_q;
    end
  end

  // Next state: a new accept replaces the request issuing in the same cycle
  always_comb begin
    pend_d        = accept | (pend_q & ~issue_b);
    req_write_d   = accept ? B_WRITE : req_write_q;
    req_wen_d     = accept ? B_WEN   : req_wen_q;
    req_addr_d    = accept ? B_ADDR  : req_addr_q;
    req_wdata_d   = accept ? B_WDATA : req_wdata_q;
    rd_inflight_d = issue_b & ~req_write_q;
    rd_hold_d     = rd_inflight_q ? M_RDATA : rd_hold_q;
    wait_cnt_d    = wait_cnt_q;
    if (accept | issue_b) begin
      wait_cnt_d = 8'd0;
    end else if (pend_q & A_CS & (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // State registers; reset drops any pending or in-flight B traffic
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q        <= 1'b0;
      req_write_q   <= 1'b0;
      req_wen_q     <= 4'b0000;
      req_addr_q    <= '0;
      req_wdata_q   <= 32'd0;
      rd_inflight_q <= 1'b0;
      rd_hold_q     <= 32'd0;
      wait_cnt_q    <= 8'd0;
    end else begin
      pend_q        <= pend_d;
      req_write_q   <= req_write_d;
      req_wen_q     <= req_wen_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      rd_inflight_q <= rd_inflight_d;
      rd_hold_q     <= rd_hold_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign B_READY  = b_ready;
  assign B_RVALID = rd_inflight_q;
  assign B_RDATA  = rd_inflight_q ? M_RDATA : rd_hold_q;
  assign A_RDATA  = M_RDATA;
  assign WAIT_CNT = wait_cnt_q;
  assign STARVE   = pend_q & (wait_cnt_q >= STARVE_LIM);

endmodule
